// File: rtl/alu_seq_ctrl.sv
// Slice-serial integer ALU sequencer. Computes AND/OR/ADD/SUB/SLT SLICE bits per cycle, LS slice first.
// Latency: N = WIDTH/SLICE cycles from the accepting edge to the done pulse (4 with defaults).
// Backpressure: start is ignored while busy; it is accepted in IDLE or in the one-cycle DONE state.
// Optional overflow trap is built with ALU_SEQ_OVF_TRAP_EN defined (sticky ovf_trap, suppressed write-back).
module alu_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       operation,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             trap_clr,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             zero,
  output logic             ovf_trap
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = $clog2(N + 1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic             accept;
  logic             last;
  logic             complete;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, acc;
  logic             a_msb, b_msb;

  logic             is_sub;
  logic [SLICE-1:0] b_sl;
  logic [SLICE:0]   sum_ext;
  logic [SLICE-1:0] slice_res;
  logic [WIDTH-1:0] slice_ext;
  logic [WIDTH-1:0] acc_nxt;
  logic             s_bit, ovf_add, ovf_sub;
  logic [WIDTH-1:0] fin_res;
  logic             fin_ovf;

  assign last     = (cnt == CW'(N - 1));
  assign complete = (state == RUN) && last;
  assign busy     = (state == RUN);
  assign done     = (state == DONE);

  // State register; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: accept in IDLE/DONE, run N slices, then one DONE cycle.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN:     if (last) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // One slice of the datapath plus the final flag/result resolution on the last slice.
  always_comb begin
    is_sub    = (op_q == OP_SUB) || (op_q == OP_SLT);
    b_sl      = is_sub ? ~b_q[SLICE-1:0] : b_q[SLICE-1:0];
    sum_ext   = {1'b0, a_q[SLICE-1:0]} + {1'b0, b_sl} + (SLICE + 1)'(carry);
    slice_res = '0;
    case (op_q)
      OP_AND:                 slice_res = a_q[SLICE-1:0] & b_q[SLICE-1:0];
      OP_OR:                  slice_res = a_q[SLICE-1:0] | b_q[SLICE-1:0];
      OP_ADD, OP_SUB, OP_SLT: slice_res = sum_ext[SLICE-1:0];
      default:                slice_res = '0;
    endcase
    slice_ext            = '0;
    slice_ext[SLICE-1:0] = slice_res;
    // New slice enters at the top; after N shifts slice 0 sits at the bottom.
    acc_nxt = (acc >> SLICE) | (slice_ext << (WIDTH - SLICE));

    // Only meaningful on the last slice, where sum_ext holds the sign bit.
    s_bit   = sum_ext[SLICE-1];
    ovf_add = (~a_msb & ~b_msb & s_bit) | (a_msb & b_msb & ~s_bit);
    ovf_sub = (~a_msb & b_msb & s_bit) | (a_msb & ~b_msb & ~s_bit);
    fin_res = acc_nxt;
    fin_ovf = 1'b0;
    case (op_q)
      OP_ADD: fin_ovf = ovf_add;
      OP_SUB: fin_ovf = ovf_sub;
      OP_SLT: begin
        fin_res    = '0;
        fin_res[0] = s_bit ^ ovf_sub;
      end
      default: fin_ovf = 1'b0;
    endcase
  end

  // Operand capture, slice shifting and the registered carry chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      op_q  <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      acc   <= '0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
      op_q  <= operation;
      cnt   <= '0;
      carry <= (operation == OP_SUB) || (operation == OP_SLT);
      acc   <= '0;
    end else if (state == RUN) begin
      a_q   <= a_q >> SLICE;
      b_q   <= b_q >> SLICE;
      acc   <= acc_nxt;
      carry <= sum_ext[SLICE];
      cnt   <= cnt + 1'b1;
    end
  end

`ifdef ALU_SEQ_OVF_TRAP_EN
  logic unused_cfg;
  assign unused_cfg = 1'b0;

  // Visible outputs; an overflowing op skips write-back and raises the sticky trap (set beats clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result   <= '0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      ovf_trap <= 1'b0;
    end else begin
      if (complete) begin
        overflow <= fin_ovf;
        if (!fin_ovf) begin
          result <= fin_res;
          zero   <= (fin_res == '0);
        end
      end
      if (complete && fin_ovf) ovf_trap <= 1'b1;
      else if (trap_clr)       ovf_trap <= 1'b0;
    end
  end
`else
  logic unused_trap_clr;
  assign unused_trap_clr = trap_clr;
  assign ovf_trap        = 1'b0;

  // Visible outputs update only on completion and hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result   <= '0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else if (complete) begin
      result   <= fin_res;
      overflow <= fin_ovf;
      zero     <= (fin_res == '0);
    end
  end
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with default parameters (N = 4).
// Inputs change and outputs are sampled on the falling edge.
// Trap checks follow the ALU_SEQ_OVF_TRAP_EN build setting.
module tb_alu_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  operation;
  logic [31:0] a, b;
  logic        trap_clr;
  logic        busy, done, overflow, zero, ovf_trap;
  logic [31:0] result;

  int compared   = 0;
  int mismatched = 0;

  alu_seq_ctrl #(.WIDTH(32), .SLICE(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .operation(operation),
    .a(a), .b(b), .trap_clr(trap_clr), .busy(busy), .done(done),
    .result(result), .overflow(overflow), .zero(zero), .ovf_trap(ovf_trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op, wait (bounded) for done, check latency and outputs.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] av, bv,
                        input logic [31:0] er, input logic eo, input logic ez);
    int cyc;
    @(negedge clk);
    operation = op; a = av; b = bv; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    cyc = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_latency"}, cyc, 4);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_in_done"}, busy, 0);
    chk({tag, "_result"}, result, er);
    chk({tag, "_overflow"}, overflow, eo);
    chk({tag, "_zero"}, zero, ez);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; start = 1'b0; operation = 3'b000; a = '0; b = '0; trap_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_zero", zero, 0);
    chk("rst_trap", ovf_trap, 0);
    rst_n = 1'b1;

`ifdef ALU_SEQ_OVF_TRAP_EN
    run_op("trap_add_ok", 3'b010, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0);
    chk("trap_clear_before", ovf_trap, 0);
    run_op("trap_add_ovf", 3'b010, 32'h7FFF_FFFF, 32'd1, 32'd2, 1'b1, 1'b0);
    chk("trap_set", ovf_trap, 1);
    @(negedge clk);
    chk("trap_sticky", ovf_trap, 1);
    trap_clr = 1'b1;
    @(negedge clk);
    trap_clr = 1'b0;
    chk("trap_cleared", ovf_trap, 0);
`else
    run_op("add_ovf", 3'b010, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b1, 1'b0);
    chk("trap_tied_low", ovf_trap, 0);
    trap_clr = 1'b1;
    @(negedge clk);
    trap_clr = 1'b0;
    chk("result_hold", result, 32'h8000_0000);
    run_op("sub_ovf", 3'b110, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b1, 1'b0);
    run_op("sub_zero", 3'b110, 32'd5, 32'd5, 32'd0, 1'b0, 1'b1);
    run_op("slt_neg", 3'b111, 32'hFFFF_FFFB, 32'd3, 32'd1, 1'b0, 1'b0);
    run_op("slt_ovfcorr", 3'b111, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b1);
    run_op("and", 3'b000, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0, 1'b0);
    run_op("or", 3'b001, 32'h00FF_0000, 32'h1200_0034, 32'h12FF_0034, 1'b0, 1'b0);
    run_op("add_carry", 3'b010, 32'h0000_FFFF, 32'h0000_0001, 32'h0001_0000, 1'b0, 1'b0);
    run_op("undef_op", 3'b011, 32'h1234_5678, 32'h1111_1111, 32'd0, 1'b0, 1'b1);
`endif

    // Back-to-back: start held high; second op is accepted in the DONE cycle.
    @(negedge clk);
    operation = 3'b010; a = 32'd1; b = 32'd2; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 32'd3; b = 32'd4;
    cyc = 0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("b2b1_latency", cyc, 4);
    chk("b2b1_result", result, 32'd3);
    @(posedge clk);
    @(negedge clk);
    chk("b2b2_busy", busy, 1);
    // A start with a=9 while busy must have no effect.
    a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    a = 32'd0; b = 32'd0;
    cyc = 1;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("b2b2_latency", cyc, 4);
    chk("b2b2_result", result, 32'd7);
    @(negedge clk);
    chk("b2b_no_third", busy, 0);
    chk("b2b_done_low", done, 0);

    // Reset during RUN, then a fresh ADD.
    @(negedge clk);
    operation = 3'b010; a = 32'd5; b = 32'd6; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_result", result, 0);
    chk("midrst_overflow", overflow, 0);
    chk("midrst_zero", zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_idle", busy, 0);
    chk("postrst_result", result, 0);
    run_op("add_after_rst", 3'b010, 32'd2, 32'd2, 32'd4, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
